// File: rtl/regbank_mp.sv
// regbank_mp: multi-port register bank with dual byte-enabled writes,
// optional zero register, optional write-to-read bypass and busy scoreboard.
module regbank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W/8-1:0]      wa_be,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W/8-1:0]      wb_be,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busy_nxt;
    logic                         wa_ok;
    logic                         wb_ok;
    logic                         rsv_ok;

    // Commands aimed at the hardwired zero register are dropped here.
    always_comb begin
        wa_ok  = wa_en;
        wb_ok  = wb_en;
        rsv_ok = rsv_en;
        if (ZERO_REG != 0) begin
            if (wa_addr == '0) wa_ok = 1'b0;
            if (wb_addr == '0) wb_ok = 1'b0;
            if (rsv_addr == '0) rsv_ok = 1'b0;
        end
    end

    // Byte-enabled storage update; port B is applied last so it wins a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (wa_ok && wa_be[k])
                    mem[wa_addr][k*8 +: 8] <= wa_data[k*8 +: 8];
                if (wb_ok && wb_be[k])
                    mem[wb_addr][k*8 +: 8] <= wb_data[k*8 +: 8];
            end
        end
    end

    // Busy next-state: flush is weakest, write clear beats it, reserve beats all.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (wa_ok) busy_nxt[wa_addr] = 1'b0;
        if (wb_ok) busy_nxt[wb_addr] = 1'b0;
        if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;

        assign a = rd_addr[i*ADDR_W +: ADDR_W];

        // Stored word, overlaid per byte with this cycle's merged write data.
        always_comb begin
            v = mem[a];
            if (BYPASS != 0 && !reset) begin
                for (int k = 0; k < NB; k++) begin
                    if (wb_ok && wb_addr == a && wb_be[k])
                        v[k*8 +: 8] = wb_data[k*8 +: 8];
                    else if (wa_ok && wa_addr == a && wa_be[k])
                        v[k*8 +: 8] = wa_data[k*8 +: 8];
                end
            end
            if (ZERO_REG != 0 && a == '0) v = '0;
        end

        assign rd_data[i*DATA_W +: DATA_W] = v;
        assign rd_busy[i] = busy[a] && !(ZERO_REG != 0 && a == '0);
    end

endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: checks three regbank_mp configurations against a
// word/byte-level reference model and directed scenarios.
module tb_regbank_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic        wa_en, wb_en, rsv_en, flush;
    logic [4:0]  wa_addr, wb_addr, rsv_addr;
    logic [3:0]  wa_be, wb_be;
    logic [31:0] wa_data, wb_data;

    logic [11:0]  c_rd_addr;
    logic [255:0] c_rd_data;
    logic [3:0]   c_rd_busy;
    logic         c_wa_en, c_wb_en, c_rsv_en, c_flush;
    logic [2:0]   c_wa_addr, c_wb_addr, c_rsv_addr;
    logic [7:0]   c_wa_be, c_wb_be;
    logic [63:0]  c_wa_data, c_wb_data;

    int errors = 0;
    int checks = 0;

    // model: instance 0 = zero reg + bypass, instance 1 = neither
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];

    always #5 clk = ~clk;

    regbank_mp #(.ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wa_en(wa_en), .wa_addr(wa_addr), .wa_be(wa_be),
        .wa_data(wa_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_be(wb_be),
        .wb_data(wb_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    regbank_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wa_en(wa_en), .wa_addr(wa_addr), .wa_be(wa_be),
        .wa_data(wa_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_be(wb_be),
        .wb_data(wb_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    regbank_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4)) dut_c (
        .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wa_en(c_wa_en), .wa_addr(c_wa_addr),
        .wa_be(c_wa_be), .wa_data(c_wa_data), .wb_en(c_wb_en),
        .wb_addr(c_wb_addr), .wb_be(c_wb_be), .wb_data(c_wb_data),
        .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr), .flush(c_flush)
    );

    function automatic bit zr(int n);
        return n == 0;
    endfunction

    // Expected read word: stored word, bypass overlay, zero register rule.
    function automatic logic [31:0] exp_rd(int n, logic [4:0] a);
        logic [31:0] v;
        v = m_mem[n][a];
        if (n == 0 && !reset) begin
            for (int k = 0; k < 4; k++) begin
                if (wb_en && wb_addr == a && wb_be[k])
                    v[k*8 +: 8] = wb_data[k*8 +: 8];
                else if (wa_en && wa_addr == a && wa_be[k])
                    v[k*8 +: 8] = wa_data[k*8 +: 8];
            end
        end
        if (zr(n) && a == 0) v = 32'h0;
        return v;
    endfunction

    task automatic model_step();
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) begin
                    m_mem[n][r]  = 32'h0;
                    m_busy[n][r] = 1'b0;
                end
            end else begin
                for (int r = 0; r < 32; r++) begin
                    bit rs, wr;
                    rs = rsv_en && rsv_addr == r && !(zr(n) && r == 0);
                    wr = ((wa_en && wa_addr == r) || (wb_en && wb_addr == r))
                         && !(zr(n) && r == 0);
                    if (rs)         m_busy[n][r] = 1'b1;
                    else if (wr)    m_busy[n][r] = 1'b0;
                    else if (flush) m_busy[n][r] = 1'b0;
                end
                for (int k = 0; k < 4; k++) begin
                    if (wa_en && wa_be[k] && !(zr(n) && wa_addr == 0))
                        m_mem[n][wa_addr][k*8 +: 8] = wa_data[k*8 +: 8];
                end
                for (int k = 0; k < 4; k++) begin
                    if (wb_en && wb_be[k] && !(zr(n) && wb_addr == 0))
                        m_mem[n][wb_addr][k*8 +: 8] = wb_data[k*8 +: 8];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = 0; wa_be = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_be = 0; wb_data = 0;
        rsv_en = 0; rsv_addr = 0; flush = 0;
    endtask

    task automatic c_idle();
        c_wa_en = 0; c_wa_addr = 0; c_wa_be = 0; c_wa_data = 0;
        c_wb_en = 0; c_wb_addr = 0; c_wb_be = 0; c_wb_data = 0;
        c_rsv_en = 0; c_rsv_addr = 0; c_flush = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); rd_addr = 0;
        tick(); tick();
        reset = 0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            checks++;
            if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b0) begin
                errors++;
                $display("FAIL reset_a a=%0d: got %h/%b want 0/00",
                         a, rd_data_a, rd_busy_a);
            end
            checks++;
            if (rd_data_b !== 64'h0 || rd_busy_b !== 2'b0) begin
                errors++;
                $display("FAIL reset_b a=%0d: got %h/%b want 0/00",
                         a, rd_data_b, rd_busy_b);
            end
        end
        wa_en = 1; wa_addr = 5; wa_be = 4'hF; wa_data = 32'hDEADBEEF;
        rsv_en = 1; rsv_addr = 7;
        tick();
        idle(); rd_addr = {5'd7, 5'd5};
        #2;
        checks++;
        if (rd_data_b[31:0] !== 32'hDEADBEEF || rd_busy_b[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_b: got %h/%b want deadbeef/1",
                     rd_data_b[31:0], rd_busy_b[1]);
        end
        reset = 1;
        wa_en = 1; wa_addr = 5; wa_be = 4'hF; wa_data = 32'h55555555;
        #2;
        checks++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_no_bypass: got %h want deadbeef",
                     rd_data_a[31:0]);
        end
        tick();
        reset = 0; idle();
        #2;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || rd_busy_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_a: got %h/%b want 0/0",
                     rd_data_a[31:0], rd_busy_a[1]);
        end
        checks++;
        if (rd_data_b[31:0] !== 32'h0 || rd_busy_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_b: got %h/%b want 0/0",
                     rd_data_b[31:0], rd_busy_b[1]);
        end
    endtask

    task automatic test_byte_collision();
        idle();
        wa_en = 1; wa_addr = 3; wa_be = 4'hF; wa_data = 32'h11223344;
        tick();
        wa_en = 1; wa_addr = 3; wa_be = 4'b0011; wa_data = 32'hAAAAAAAA;
        wb_en = 1; wb_addr = 3; wb_be = 4'b0110; wb_data = 32'hBBBBBBBB;
        rd_addr = {5'd0, 5'd3};
        #2;
        checks++;
        if (rd_data_a[31:0] !== 32'h11BBBBAA) begin
            errors++;
            $display("FAIL collide_bypass_a: got %h want 11bbbbaa",
                     rd_data_a[31:0]);
        end
        checks++;
        if (rd_data_b[31:0] !== 32'h11223344) begin
            errors++;
            $display("FAIL collide_old_b: got %h want 11223344",
                     rd_data_b[31:0]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (rd_data_a[31:0] !== 32'h11BBBBAA || rd_data_b[31:0] !== 32'h11BBBBAA) begin
            errors++;
            $display("FAIL collide_after: got %h,%h want 11bbbbaa",
                     rd_data_a[31:0], rd_data_b[31:0]);
        end
        rsv_en = 1; rsv_addr = 3;
        tick();
        idle();
        wa_en = 1; wa_addr = 3; wa_be = 4'h0; wa_data = 32'hFFFFFFFF;
        tick();
        idle();
        #2;
        checks++;
        if (rd_data_a[31:0] !== 32'h11BBBBAA || rd_busy_a[0] !== 1'b0
            || rd_data_b[31:0] !== 32'h11BBBBAA || rd_busy_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_clear: got %h/%b,%h/%b want 11bbbbaa/0",
                     rd_data_a[31:0], rd_busy_a[0], rd_data_b[31:0], rd_busy_b[0]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wa_en = 1; wa_addr = 0; wa_be = 4'hF; wa_data = 32'hFFFFFFFF;
        rsv_en = 1; rsv_addr = 0;
        rd_addr = {5'd0, 5'd0};
        #2;
        checks++;
        if (rd_data_a !== 64'h0) begin
            errors++;
            $display("FAIL zero_bypass_a: got %h want 0", rd_data_a);
        end
        tick();
        idle();
        #2;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || rd_busy_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_a: got %h/%b want 0/0",
                     rd_data_a[31:0], rd_busy_a[0]);
        end
        checks++;
        if (rd_data_b[31:0] !== 32'hFFFFFFFF || rd_busy_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL nozero_b: got %h/%b want ffffffff/1",
                     rd_data_b[31:0], rd_busy_b[0]);
        end
    endtask

    task automatic test_bypass();
        idle();
        wa_en = 1; wa_addr = 9; wa_be = 4'hF; wa_data = 32'hCAFEF00D;
        tick();
        wa_data = 32'h12345678;
        rd_addr = {5'd9, 5'd9};
        #2;
        checks++;
        if (rd_data_a[63:32] !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_a: got %h want 12345678", rd_data_a[63:32]);
        end
        checks++;
        if (rd_data_b[63:32] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL nobypass_b: got %h want cafef00d", rd_data_b[63:32]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (rd_data_a[31:0] !== 32'h12345678 || rd_data_b[31:0] !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_after: got %h,%h want 12345678",
                     rd_data_a[31:0], rd_data_b[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_addr = {5'd4, 5'd4};
        rsv_en = 1; rsv_addr = 4;
        tick();
        idle();
        #2;
        checks++;
        if (rd_busy_a !== 2'b11 || rd_busy_b !== 2'b11) begin
            errors++;
            $display("FAIL rsv_r4: got %b,%b want 11", rd_busy_a, rd_busy_b);
        end
        rsv_en = 1; rsv_addr = 4;
        wa_en = 1; wa_addr = 4; wa_be = 4'hF; wa_data = 32'h4;
        tick();
        idle();
        #2;
        checks++;
        if (rd_busy_a !== 2'b11 || rd_busy_b !== 2'b11) begin
            errors++;
            $display("FAIL rsv_beats_write: got %b,%b want 11",
                     rd_busy_a, rd_busy_b);
        end
        wa_en = 1; wa_addr = 4; wa_be = 4'hF; wa_data = 32'h44;
        tick();
        idle();
        #2;
        checks++;
        if (rd_busy_a !== 2'b00 || rd_busy_b !== 2'b00) begin
            errors++;
            $display("FAIL write_clears: got %b,%b want 00", rd_busy_a, rd_busy_b);
        end
        rsv_en = 1; rsv_addr = 2;
        tick();
        rsv_addr = 6;
        tick();
        rsv_addr = 8; flush = 1;
        tick();
        idle();
        for (int a = 0; a < 32; a++) begin
            logic w;
            w = (a == 8);
            rd_addr = {5'(a), 5'(a)};
            #1;
            checks++;
            if (rd_busy_a !== {w, w} || rd_busy_b !== {w, w}) begin
                errors++;
                $display("FAIL flush_rsv a=%0d: got %b,%b want %b%b",
                         a, rd_busy_a, rd_busy_b, w, w);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset    = ($urandom_range(0, 49) == 0);
            wa_en    = $urandom_range(0, 1);
            wa_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wa_be    = 4'($urandom);
            wa_data  = $urandom;
            wb_en    = $urandom_range(0, 1);
            wb_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wb_be    = 4'($urandom);
            wb_data  = $urandom;
            rsv_en   = $urandom_range(0, 1);
            rsv_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 9) == 0);
            rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #2;
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  a;
                logic [31:0] ea, eb;
                a  = rd_addr[p*5 +: 5];
                ea = exp_rd(0, a);
                eb = exp_rd(1, a);
                checks++;
                if (rd_data_a[p*32 +: 32] !== ea || rd_busy_a[p] !== m_busy[0][a]) begin
                    errors++;
                    $display("FAIL rand_a cyc=%0d p=%0d r%0d: got %h/%b want %h/%b",
                             cyc, p, a, rd_data_a[p*32 +: 32], rd_busy_a[p],
                             ea, m_busy[0][a]);
                end
                checks++;
                if (rd_data_b[p*32 +: 32] !== eb || rd_busy_b[p] !== m_busy[1][a]) begin
                    errors++;
                    $display("FAIL rand_b cyc=%0d p=%0d r%0d: got %h/%b want %h/%b",
                             cyc, p, a, rd_data_b[p*32 +: 32], rd_busy_b[p],
                             eb, m_busy[1][a]);
                end
            end
            tick();
        end
        reset = 0;
        idle();
    endtask

    task automatic test_multi_read();
        logic [63:0] k;
        k = 64'h0101010101010101;
        c_idle();
        for (int i = 0; i < 8; i += 2) begin
            c_wa_en = 1; c_wa_addr = 3'(i);     c_wa_be = 8'hFF; c_wa_data = 64'(i) * k;
            c_wb_en = 1; c_wb_addr = 3'(i + 1); c_wb_be = 8'hFF; c_wb_data = 64'(i + 1) * k;
            tick();
        end
        c_idle();
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++)
                c_rd_addr[p*3 +: 3] = 3'(p * 3 + r * 5 + 1);
            #1;
            for (int p = 0; p < 4; p++) begin
                logic [63:0] e;
                e = 64'(c_rd_addr[p*3 +: 3]) * k;
                checks++;
                if (c_rd_data[p*64 +: 64] !== e || c_rd_busy[p] !== 1'b0) begin
                    errors++;
                    $display("FAIL multi r=%0d p=%0d: got %h/%b want %h/0",
                             r, p, c_rd_data[p*64 +: 64], c_rd_busy[p], e);
                end
            end
        end
        c_rd_addr = {3'd5, 3'd2, 3'd5, 3'd7};
        c_wa_en = 1; c_wa_addr = 5; c_wa_be = 8'h0F; c_wa_data = 64'hFEDCBA9876543210;
        #2;
        checks++;
        if (c_rd_data[63:0] !== 7 * k || c_rd_data[127:64] !== 64'h0505050576543210
            || c_rd_data[191:128] !== 2 * k || c_rd_data[255:192] !== 64'h0505050576543210) begin
            errors++;
            $display("FAIL multi_bypass: got %h want 0505050576543210 on ports 1,3",
                     c_rd_data);
        end
        tick();
        c_idle();
    endtask

    initial begin
        idle();
        c_idle();
        reset = 1;
        rd_addr = 0;
        c_rd_addr = 0;
        test_reset();
        test_byte_collision();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_multi_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
